if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage with a FETCH/HOLD/DROP request FSM and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic        pc_src_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc_plus4,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        accept;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign accept         = pc_write & IF_ID_write;
  assign redirect       = pc_src_branch & IF_ID_write;
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = branch_target & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 32'h0;
      buf_q        <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      buf_q        <= buf_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    buf_d        = buf_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d         = target_aligned;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          if (!imem_ready) begin
            // Request still in flight: remember its address so imem_addr stays stable.
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          if (accept) begin
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
            if (IF_ID_write) begin
              ifid_instr_d = 32'h0;
              ifid_valid_d = 1'b0;
            end
          end
        end else if (IF_ID_write) begin
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d         = target_aligned;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (accept) begin
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = buf_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = target_aligned;
        end
        if (IF_ID_write) begin
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
        end
        if (imem_ready) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem_req       = (state_q != S_HOLD);
  assign imem_addr      = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign fetch_busy     = (state_q != S_FETCH);
  assign IF_ID_pc_plus4 = ifid_pc4_q;
  assign IF_ID_instr    = ifid_instr_q;
  assign IF_ID_valid    = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_evt;

  assign stall_evt = (state_q == S_HOLD) || ((state_q == S_FETCH) && !imem_ready);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
